// File: rtl/papuf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// papuf_ctrl_pkg
// Shared definitions for the pulse-arbiter PUF evaluation controller:
//   - state_t      : sequencer states
//   - DEF_*        : default widths and timing used by the controller
//   - cnt_width()  : bits needed to hold the values 0..maxval (minimum 1)
// -----------------------------------------------------------------------------
package papuf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int DEF_CW       = 16;
    localparam int DEF_RW       = 16;
    localparam int DEF_PULSE_W  = 4;
    localparam int DEF_SETTLE_W = 8;
    localparam int DEF_NREP     = 5;

    function automatic int cnt_width(input int maxval);
        if (maxval < 1) begin
            return 1;
        end
        return $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/papuf_vote_acc.sv
// -----------------------------------------------------------------------------
// papuf_vote_acc
// Per-bit ones counters for repeated PUF evaluations plus the majority vote
// and instability flags derived from them.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            clears all counters (request accepted)
//   sample         adds the current response bits to the counters
//   bits[RW]       raw array response
//   vote[RW]       1 where more than half of the repeats returned 1
//   unstable[RW]   1 where the repeats did not all agree
// -----------------------------------------------------------------------------
module papuf_vote_acc
    import papuf_ctrl_pkg::*;
#(
    parameter int RW   = DEF_RW,
    parameter int NREP = DEF_NREP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sample,
    input  logic [RW-1:0] bits,
    output logic [RW-1:0] vote,
    output logic [RW-1:0] unstable
);

    localparam int            OW   = cnt_width(NREP);
    localparam logic [OW-1:0] HALF = OW'(NREP / 2);
    localparam logic [OW-1:0] FULL = OW'(NREP);

    generate
        for (genvar gi = 0; gi < RW; gi++) begin : g_bit
            logic [OW-1:0] ones_reg;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    ones_reg <= '0;
                end else if (sample && bits[gi]) begin
                    ones_reg <= ones_reg + 1'b1;
                end
            end

            // NREP is odd, so "more than half" never ties.
            assign vote[gi]     = (ones_reg > HALF);
            assign unstable[gi] = (ones_reg != '0) && (ones_reg != FULL);
        end
    endgenerate

endmodule

// File: rtl/papuf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// papuf_eval_ctrl
// Sequencer for the 16x16 pulse-arbiter PUF array: accepts a challenge,
// drives it to the array, fires a launch pulse, waits a settle window,
// captures the response and returns it over a valid/ready port.
// Optional feature macro: PAPUF_MAJ_VOTE_EN -- repeat the pulse/settle/capture
// loop NREP times and return the per-bit majority plus disagreement flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      challenge request handshake (ready only in IDLE)
//   req_challenge[CW]        challenge to evaluate
//   puf_challenge[CW]        registered challenge to the array
//   puf_pulse                registered launch pulse to the array
//   puf_response[RW]         raw array response, sampled in CAPTURE
//   rsp_valid/rsp_ready      response handshake
//   rsp_data[RW]             evaluated (or majority-voted) response
//   rsp_unstable[RW]         per-bit disagreement across repeats (vote only)
//   busy                     high in every state except IDLE
// -----------------------------------------------------------------------------
module papuf_eval_ctrl
    import papuf_ctrl_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int RW       = DEF_RW,
    parameter int PULSE_W  = DEF_PULSE_W,
    parameter int SETTLE_W = DEF_SETTLE_W,
    parameter int NREP     = DEF_NREP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_challenge,
    output logic [CW-1:0] puf_challenge,
    output logic          puf_pulse,
    input  logic [RW-1:0] puf_response,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_data,
    output logic [RW-1:0] rsp_unstable,
    output logic          busy
);

    localparam int PW_EFF = (PULSE_W < 1) ? 1 : PULSE_W;
    localparam int CNTW   = cnt_width((PW_EFF > SETTLE_W) ? PW_EFF : SETTLE_W);
    localparam logic [CNTW-1:0] PULSE_LOAD  = CNTW'(PW_EFF - 1);
    localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'((SETTLE_W > 0) ? SETTLE_W - 1 : 0);

`ifdef PAPUF_MAJ_VOTE_EN
    localparam int REPS = NREP;
`else
    localparam int REPS = 1;
`endif
    // Repeat counter is sized for NREP in both builds so the datapath is shared.
    localparam int              REPW     = cnt_width(NREP);
    localparam logic [REPW-1:0] LAST_REP = REPW'(REPS - 1);

    state_t          state_reg, state_next;
    logic [CNTW-1:0] cnt_reg;
    logic [REPW-1:0] rep_reg;
    logic [CW-1:0]   puf_challenge_reg;
    logic            puf_pulse_reg;
    logic            accept;
    logic            capture_en;

    assign accept     = req_valid && req_ready;
    assign capture_en = (state_reg == CAPTURE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = SETUP;
            SETUP:   state_next = PULSE;
            PULSE:   if (cnt_reg == '0) state_next = (SETTLE_W > 0) ? SETTLE : CAPTURE;
            SETTLE:  if (cnt_reg == '0) state_next = CAPTURE;
            CAPTURE: state_next = (rep_reg == LAST_REP) ? DONE : PULSE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        rsp_valid = (state_reg == DONE);
    end

    // Counters, challenge and pulse registers. The pulse register follows the
    // state the FSM is entering, so it is high exactly during PULSE cycles
    // without any combinational path to the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            puf_challenge_reg <= '0;
            puf_pulse_reg     <= 1'b0;
            cnt_reg           <= '0;
            rep_reg           <= '0;
        end else begin
            puf_pulse_reg <= (state_next == PULSE);

            if (accept) begin
                puf_challenge_reg <= req_challenge;
                rep_reg           <= '0;
            end else if (capture_en) begin
                rep_reg <= rep_reg + 1'b1;
            end

            // Load on entry, count down to zero while the state holds.
            if (state_next != state_reg) begin
                case (state_next)
                    PULSE:   cnt_reg <= PULSE_LOAD;
                    SETTLE:  cnt_reg <= SETTLE_LOAD;
                    default: cnt_reg <= '0;
                endcase
            end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign puf_challenge = puf_challenge_reg;
    assign puf_pulse     = puf_pulse_reg;

`ifdef PAPUF_MAJ_VOTE_EN
    papuf_vote_acc #(
        .RW   (RW),
        .NREP (NREP)
    ) u_vote_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .sample   (capture_en),
        .bits     (puf_response),
        .vote     (rsp_data),
        .unstable (rsp_unstable)
    );
`else
    logic [RW-1:0] rsp_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_reg <= '0;
        end else if (capture_en) begin
            rsp_data_reg <= puf_response;
        end
    end

    assign rsp_data     = rsp_data_reg;
    assign rsp_unstable = '0;
`endif

endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_papuf_eval_ctrl
// Self-checking bench for papuf_eval_ctrl. Instance A uses the default timing,
// instance B uses PULSE_W=0 / SETTLE_W=0. A behavioural array model returns
// hash(challenge) ^ flips[rep] for each launch pulse; expected responses are
// the per-bit majority over the repeats. Honours PAPUF_MAJ_VOTE_EN.
// Latency convention: the accept cycle is cycle 0; rsp_valid is expected high
// in cycle 2 + REPS*(max(PULSE_W,1)+SETTLE_W+1).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_papuf_eval_ctrl;

    localparam int CW   = 16;
    localparam int RW   = 16;
    localparam int PW   = 4;
    localparam int SW   = 8;
    localparam int NREP = 5;
`ifdef PAPUF_MAJ_VOTE_EN
    localparam int REPS = NREP;
`else
    localparam int REPS = 1;
`endif
    localparam int PW_EFF = (PW < 1) ? 1 : PW;
    localparam int LAT_A  = 2 + REPS * (PW_EFF + SW + 1);
    localparam int LAT_B  = 2 + REPS * (1 + 0 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_req_valid = 1'b0, a_req_ready, a_puf_pulse, a_rsp_valid, a_busy;
    logic          a_rsp_ready = 1'b0;
    logic [CW-1:0] a_req_ch = '0, a_puf_ch;
    logic [RW-1:0] a_puf_rsp = '0, a_rsp_data, a_rsp_unst;

    logic          b_req_valid = 1'b0, b_req_ready, b_puf_pulse, b_rsp_valid, b_busy;
    logic          b_rsp_ready = 1'b0;
    logic [CW-1:0] b_req_ch = '0, b_puf_ch;
    logic [RW-1:0] b_puf_rsp, b_rsp_data, b_rsp_unst;

    int errors = 0;
    int checks = 0;

    logic [15:0] flips [8];
    int a_rises = 0, a_hi = 0, a_base = 0, a_hi_base = 0;
    int b_rises = 0, b_hi = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;

    papuf_eval_ctrl u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_challenge(a_req_ch),
        .puf_challenge(a_puf_ch), .puf_pulse(a_puf_pulse), .puf_response(a_puf_rsp),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .rsp_unstable(a_rsp_unst), .busy(a_busy)
    );

    papuf_eval_ctrl #(.PULSE_W(0), .SETTLE_W(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_challenge(b_req_ch),
        .puf_challenge(b_puf_ch), .puf_pulse(b_puf_pulse), .puf_response(b_puf_rsp),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_unstable(b_rsp_unst), .busy(b_busy)
    );

    // Ideal (noise-free) array response for a challenge.
    function automatic logic [15:0] puf_base(input logic [15:0] ch);
        logic [15:0] m;
        m = ch * 16'h9E37;
        return {ch[7:0], ch[15:8]} ^ m ^ 16'h3C5A;
    endfunction

    // Majority (want_unstable=0) or disagreement mask (want_unstable=1) over
    // REPS noisy evaluations of ch.
    function automatic logic [15:0] exp_vote(input logic [15:0] ch, input bit want_unstable);
        logic [15:0] d, u, v;
        int ones;
        d = '0;
        u = '0;
        for (int i = 0; i < 16; i++) begin
            ones = 0;
            for (int r = 0; r < REPS; r++) begin
                v = puf_base(ch) ^ flips[r];
                ones += int'(v[i]);
            end
            d[i] = (2 * ones > REPS);
            u[i] = (ones != 0) && (ones != REPS);
        end
        return want_unstable ? u : d;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Array model for A: a new noisy response per launch pulse.
    always @(posedge clk) begin
        #1;
        if (a_puf_pulse && !a_prev) begin
            a_puf_rsp = puf_base(a_puf_ch) ^ flips[(a_rises - a_base) & 7];
            a_rises++;
        end
        if (a_puf_pulse) a_hi++;
        a_prev = a_puf_pulse;
        if (b_puf_pulse && !b_prev) b_rises++;
        if (b_puf_pulse) b_hi++;
        b_prev = b_puf_pulse;
    end

    assign b_puf_rsp = puf_base(b_puf_ch);

    task automatic a_accept(input logic [15:0] ch);
        a_req_ch    = ch;
        a_req_valid = 1'b1;
        a_base      = a_rises;
        a_hi_base   = a_hi;
        check_eq("accept_ready", a_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        check_eq("challenge_latched", a_puf_ch, ch);
    endtask

    task automatic a_await(input logic [15:0] ch, input string tag);
        int lat;
        bit bad_busy;
        lat      = 1;
        bad_busy = 1'b0;
        while (!a_rsp_valid && lat < 400) begin
            if (!a_busy || a_req_ready) bad_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, LAT_A);
        check_eq({tag, "_data"}, a_rsp_data, exp_vote(ch, 1'b0));
        check_eq({tag, "_unstable"}, a_rsp_unst, exp_vote(ch, 1'b1));
        check_eq({tag, "_pulses"}, a_rises - a_base, REPS);
        check_eq({tag, "_pulse_cycles"}, a_hi - a_hi_base, REPS * PW_EFF);
        check_eq({tag, "_busy"}, bad_busy, 0);
        $display("txn %s ch=%h rsp=%h unstable=%h latency=%0d", tag, ch, a_rsp_data, a_rsp_unst, lat);
    endtask

    task automatic a_release(input int hold, input bit poke);
        logic [15:0] d0, u0, c0;
        bit bad;
        d0  = a_rsp_data;
        u0  = a_rsp_unst;
        c0  = a_puf_ch;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == hold / 2) begin
                a_req_valid = 1'b1;
                a_req_ch    = ~c0;
            end else begin
                a_req_valid = 1'b0;
            end
            @(negedge clk);
            if (a_rsp_data !== d0 || a_rsp_unst !== u0 || !a_rsp_valid || a_req_ready || !a_busy)
                bad = 1'b1;
        end
        a_req_valid = 1'b0;
        check_eq("done_hold_stable", bad, 0);
        check_eq("done_challenge_held", a_puf_ch, c0);
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        check_eq("release_idle", {a_rsp_valid, a_busy, a_req_ready}, 3'b001);
        check_eq("challenge_kept_idle", a_puf_ch, c0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ch, ch2;
        int n, lat;
        bit bad;

        for (int r = 0; r < 8; r++) flips[r] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_ctrl", {a_req_ready, a_puf_pulse, a_rsp_valid, a_busy}, 4'b1000);
        check_eq("rst_a_challenge", a_puf_ch, 0);
        check_eq("rst_a_data", {a_rsp_data, a_rsp_unst}, 0);
        check_eq("rst_b_ctrl", {b_req_ready, b_puf_pulse, b_rsp_valid, b_busy}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);

        // 1: single evaluation with the noise-free model
        a_accept(16'hA5C3);
        a_await(16'hA5C3, "t1");
        a_release(0, 1'b0);

        // 2: response held in DONE, stray request ignored
        for (int r = 0; r < 8; r++) flips[r] = 16'($urandom);
        a_accept(16'h0F0F);
        a_await(16'h0F0F, "t2");
        a_release(20, 1'b1);

        // 3: reset during the second pulse cycle
        a_accept(16'h5AA5);
        n = 0;
        while (!a_puf_pulse && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_pulse_seen", a_puf_pulse, 1);
        @(negedge clk);
        check_eq("t3_pulse_2nd", a_puf_pulse, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t3_abort", {a_puf_pulse, a_busy, a_req_ready, a_rsp_valid}, 4'b0010);
        check_eq("t3_challenge_cleared", a_puf_ch, 0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (a_rsp_valid || a_busy) bad = 1'b1;
        end
        check_eq("t3_no_rsp", bad, 0);
        $display("txn t3 reset abort ch=5aa5");
        a_accept(16'h5AA5);
        a_await(16'h5AA5, "t3r");
        a_release(1, 1'b0);

        // 4: bit 3 flips on two of five repeats
        for (int r = 0; r < 8; r++) flips[r] = '0;
        flips[1] = 16'h0008;
        flips[3] = 16'h0008;
        a_accept(16'h3C96);
        a_await(16'h3C96, "t4");
`ifdef PAPUF_MAJ_VOTE_EN
        check_eq("t4_unstable_mask", a_rsp_unst, 16'h0008);
`endif
        a_release(2, 1'b0);

        // 5: zero-width pulse and settle on instance B
        b_req_ch    = 16'h1357;
        b_req_valid = 1'b1;
        n           = b_rises;
        lat         = b_hi;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        ch = 16'h1357;
        begin
            int bl;
            bl = 1;
            while (!b_rsp_valid && bl < 100) begin
                @(negedge clk);
                bl++;
            end
            check_eq("t5_latency", bl, LAT_B);
            $display("txn t5 ch=%h rsp=%h latency=%0d", ch, b_rsp_data, bl);
        end
        check_eq("t5_data", b_rsp_data, puf_base(ch));
        check_eq("t5_unstable", b_rsp_unst, 0);
        check_eq("t5_pulses", b_rises - n, REPS);
        check_eq("t5_pulse_cycles", b_hi - lat, REPS);
        b_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_rsp_ready = 1'b0;
        check_eq("t5_release", {b_rsp_valid, b_busy, b_req_ready}, 3'b001);

        // 6: back-to-back requests
        for (int r = 0; r < 8; r++) flips[r] = 16'($urandom);
        ch  = 16'($urandom);
        ch2 = ~ch ^ 16'h00FF;
        a_accept(ch);
        a_await(ch, "t6a");
        a_rsp_ready = 1'b1;
        a_req_valid = 1'b1;
        a_req_ch    = ch2;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_idle_gap", {a_rsp_valid, a_busy, a_req_ready}, 3'b001);
        a_base    = a_rises;
        a_hi_base = a_hi;
        for (int r = 0; r < 8; r++) flips[r] = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b0;
        check_eq("t6_second_accept", {a_busy, a_req_ready}, 2'b10);
        check_eq("t6_second_challenge", a_puf_ch, ch2);
        a_await(ch2, "t6b");
        a_release(0, 1'b0);

        // Randomised transactions
        for (int t = 0; t < 8; t++) begin
            ch = 16'($urandom);
            for (int r = 0; r < 8; r++) flips[r] = 16'($urandom);
            a_accept(ch);
            a_await(ch, "rnd");
            a_release(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
